// File: rtl/serial_pair_tx_if.sv
// Operand-pair load handshake and serial output bundle for serial_pair_tx.
// master: operand source / line consumer; slave: the serializer itself.
interface serial_pair_tx_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             line1;
    logic             line2;
    logic             frame;
    logic             exp_sum;
    logic             exp_ovf;
    logic             done;

    modport master (
        output load_valid,
        output op_a,
        output op_b,
        input  load_ready,
        input  line1,
        input  line2,
        input  frame,
        input  exp_sum,
        input  exp_ovf,
        input  done
    );

    modport slave (
        input  load_valid,
        input  op_a,
        input  op_b,
        output load_ready,
        output line1,
        output line2,
        output frame,
        output exp_sum,
        output exp_ovf,
        output done
    );
endinterface

// File: rtl/serial_pair_tx.sv
// Serializes an operand pair LSB first on two lines, alongside the
// expected serial-adder sum bit and the final carry as overflow.
module serial_pair_tx #(
    parameter int WIDTH = 8
) (
    input logic               clock,
    input logic               reset,
    serial_pair_tx_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             ready;
    logic             accept;
    logic             last;
    logic             bit_a;
    logic             bit_b;

    assign accept = bus.load_valid && ready;
    assign last   = (cnt == CW'(WIDTH - 1));
    assign bit_a  = sh_a[0];
    assign bit_b  = sh_b[0];

    // State register; the unused encoding falls back to IDLE via next-state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: one frame is WIDTH shift cycles then a single DONE cycle
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = accept ? SHIFT : IDLE;
            SHIFT:   state_nx = last ? DONE : SHIFT;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: capture on accept, then shift and ripple the carry each bit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh_a  <= '0;
            sh_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sh_a  <= bus.op_a;
                        sh_b  <= bus.op_b;
                        carry <= 1'b0;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
                    sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
                    carry <= (bit_a & bit_b) | (bit_a & carry) | (bit_b & carry);
                    cnt   <= cnt + CW'(1);
                end
                default: begin
                    sh_a  <= sh_a;
                    sh_b  <= sh_b;
                    carry <= carry;
                    cnt   <= cnt;
                end
            endcase
        end
    end

    // Outputs decoded from registered state only; ready is held low in reset
    always_comb begin
        ready       = 1'b0;
        bus.line1   = 1'b0;
        bus.line2   = 1'b0;
        bus.frame   = 1'b0;
        bus.exp_sum = 1'b0;
        bus.exp_ovf = 1'b0;
        bus.done    = 1'b0;
        case (state)
            IDLE: begin
                ready = !reset;
            end
            SHIFT: begin
                bus.frame   = 1'b1;
                bus.line1   = bit_a;
                bus.line2   = bit_b;
                bus.exp_sum = bit_a ^ bit_b ^ carry;
            end
            DONE: begin
                bus.done    = 1'b1;
                bus.exp_ovf = carry;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    assign bus.load_ready = ready;

endmodule

// File: tb/tb_serial_pair_tx.sv
// Directed self-checking bench for serial_pair_tx at WIDTH=8.
// Inputs change 1ns after rising edges; outputs are sampled on falling edges.
module tb_serial_pair_tx;
    localparam int W = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    serial_pair_tx_if #(.WIDTH(W)) bus ();

    serial_pair_tx #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Offer one pair, then record the frame; operands are scrambled after accept
    task automatic send(
        input  logic [W-1:0] a,
        input  logic [W-1:0] b,
        output logic [W-1:0] l1,
        output logic [W-1:0] l2,
        output logic [W-1:0] s,
        output logic [W-1:0] f,
        output logic         mid,
        output logic         dn,
        output logic         ov,
        output logic         rdy
    );
        @(negedge clock);
        bus.load_valid = 1'b1;
        bus.op_a = a;
        bus.op_b = b;
        rdy = bus.load_ready;
        @(posedge clock);
        #1;
        bus.load_valid = 1'b0;
        bus.op_a = ~a;
        bus.op_b = ~b;
        mid = 1'b0;
        for (int k = 0; k < W; k++) begin
            @(negedge clock);
            f[k]  = bus.frame;
            l1[k] = bus.line1;
            l2[k] = bus.line2;
            s[k]  = bus.exp_sum;
            mid   = mid | bus.done | bus.exp_ovf | bus.load_ready;
        end
        @(negedge clock);
        dn = bus.done;
        ov = bus.exp_ovf;
        mid = mid | bus.frame;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.load_valid = 1'b1;
        bus.op_a = 8'h33;
        bus.op_b = 8'h44;
        repeat (2) @(negedge clock);
        n_checks++;
        if (bus.load_ready !== 1'b0) begin
            $display("FAIL reset_ready got=%b want=0", bus.load_ready);
        end else n_pass++;
        n_checks++;
        if ({bus.frame, bus.line1, bus.line2, bus.done,
             bus.exp_sum, bus.exp_ovf} !== 6'b0) begin
            $display("FAIL reset_outs got=%b want=000000",
                     {bus.frame, bus.line1, bus.line2, bus.done,
                      bus.exp_sum, bus.exp_ovf});
        end else n_pass++;
        bus.load_valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (bus.load_ready !== 1'b1 || bus.frame !== 1'b0) begin
            $display("FAIL reset_release got=%b%b want=10",
                     bus.load_ready, bus.frame);
        end else n_pass++;
    endtask

    task automatic test_vectors();
        logic [W-1:0] av [3];
        logic [W-1:0] bv [3];
        logic [W-1:0] sv [3];
        logic         ovv [3];
        logic [W-1:0] l1, l2, s, f;
        logic         mid, dn, ov, rdy;
        av = '{8'h01, 8'hFF, 8'hA5};
        bv = '{8'h01, 8'h01, 8'h5A};
        sv = '{8'h02, 8'h00, 8'hFF};
        ovv = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            send(av[i], bv[i], l1, l2, s, f, mid, dn, ov, rdy);
            n_checks++;
            if (rdy !== 1'b1) begin
                $display("FAIL vec%0d_ready got=%b want=1", i, rdy);
            end else n_pass++;
            n_checks++;
            if (f !== 8'hFF || mid !== 1'b0) begin
                $display("FAIL vec%0d_frame got=%h/%b want=ff/0", i, f, mid);
            end else n_pass++;
            n_checks++;
            if (l1 !== av[i] || l2 !== bv[i]) begin
                $display("FAIL vec%0d_lines got=%h/%h want=%h/%h",
                         i, l1, l2, av[i], bv[i]);
            end else n_pass++;
            n_checks++;
            if (s !== sv[i]) begin
                $display("FAIL vec%0d_sum got=%h want=%h", i, s, sv[i]);
            end else n_pass++;
            n_checks++;
            if (dn !== 1'b1 || ov !== ovv[i]) begin
                $display("FAIL vec%0d_done got=%b/%b want=1/%b",
                         i, dn, ov, ovv[i]);
            end else n_pass++;
            @(negedge clock);
            n_checks++;
            if (bus.done !== 1'b0 || bus.exp_ovf !== 1'b0 ||
                bus.load_ready !== 1'b1) begin
                $display("FAIL vec%0d_idle got=%b%b%b want=001",
                         i, bus.done, bus.exp_ovf, bus.load_ready);
            end else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int acc [$];
        logic [W-1:0] ca, cb;
        int idx;
        int bad;
        logic rdy;
        ca = '0;
        cb = '0;
        idx = 0;
        bad = 0;
        @(negedge clock);
        bus.load_valid = 1'b1;
        for (int n = 0; n < 35; n++) begin
            if (n > 0) @(negedge clock);
            if (bus.frame === 1'b1) begin
                if (idx >= W || bus.line1 !== ca[idx] ||
                    bus.line2 !== cb[idx]) bad++;
                idx++;
            end
            rdy = bus.load_ready;
            bus.op_a = W'($urandom);
            bus.op_b = W'($urandom);
            if (rdy === 1'b1) begin
                acc.push_back(n);
                ca = bus.op_a;
                cb = bus.op_b;
                idx = 0;
            end
        end
        @(negedge clock);
        bus.load_valid = 1'b0;
        n_checks++;
        if (acc.size() != 4) begin
            $display("FAIL b2b_count got=%0d want=4", acc.size());
        end else n_pass++;
        for (int i = 1; i < acc.size(); i++) begin
            n_checks++;
            if (acc[i] - acc[i-1] != 10) begin
                $display("FAIL b2b_spacing%0d got=%0d want=10",
                         i, acc[i] - acc[i-1]);
            end else n_pass++;
        end
        n_checks++;
        if (bad != 0) begin
            $display("FAIL b2b_lines got=%0d bad want=0", bad);
        end else n_pass++;
        repeat (12) @(negedge clock);
    endtask

    task automatic test_reset_midframe();
        logic [W-1:0] l1, l2, s, f;
        logic         mid, dn, ov, rdy;
        int           seen_done;
        @(negedge clock);
        bus.load_valid = 1'b1;
        bus.op_a = 8'hFF;
        bus.op_b = 8'hFF;
        @(posedge clock);
        #1;
        bus.load_valid = 1'b0;
        repeat (4) @(negedge clock);
        n_checks++;
        if (bus.frame !== 1'b1 || bus.exp_sum !== 1'b1) begin
            $display("FAIL mid_bit3 got=%b%b want=11",
                     bus.frame, bus.exp_sum);
        end else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.frame, bus.line1, bus.line2, bus.exp_sum, bus.done,
             bus.load_ready} !== 6'b0) begin
            $display("FAIL mid_async got=%b want=000000",
                     {bus.frame, bus.line1, bus.line2, bus.exp_sum,
                      bus.done, bus.load_ready});
        end else n_pass++;
        @(negedge clock);
        reset = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (bus.done === 1'b1 || bus.frame === 1'b1) seen_done++;
        end
        n_checks++;
        if (seen_done != 0) begin
            $display("FAIL mid_no_done got=%0d want=0", seen_done);
        end else n_pass++;
        send(8'h00, 8'h00, l1, l2, s, f, mid, dn, ov, rdy);
        n_checks++;
        if (s !== 8'h00 || f !== 8'hFF || dn !== 1'b1 || ov !== 1'b0) begin
            $display("FAIL mid_fresh got=%h/%h/%b/%b want=00/ff/1/0",
                     s, f, dn, ov);
        end else n_pass++;
        @(negedge clock);
    endtask

    task automatic test_random();
        logic [W-1:0] l1, l2, s, f;
        logic         mid, dn, ov, rdy;
        logic [W-1:0] a, b;
        logic [W:0]   want;
        logic [W:0]   got;
        for (int i = 0; i < 6; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            want = {1'b0, a} + {1'b0, b};
            send(a, b, l1, l2, s, f, mid, dn, ov, rdy);
            got = {ov, s};
            n_checks++;
            if (got !== want || dn !== 1'b1) begin
                $display("FAIL rand%0d_sum %h+%h got=%h want=%h",
                         i, a, b, got, want);
            end else n_pass++;
            @(negedge clock);
        end
    endtask

    initial begin
        bus.load_valid = 1'b0;
        bus.op_a = '0;
        bus.op_b = '0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
